// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state encoding, hold-counter width and pending-limit helper
package edge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int HOLD_W = 8;

    function automatic int pmax(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sat_req_counter.sv
// rtl/sat_req_counter.sv - saturating up/down counter for buffered edge requests
module sat_req_counter
    import edge_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(pmax(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_MAX);
    // An inc paired with a dec is a pass-through, so it can never overflow.
    assign drop_o  = inc_i & ~dec_i & full_o;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/edge_signal_generator.sv
// rtl/edge_signal_generator.sv - turns edge-request ticks into a level with a minimum hold
// between toggles; requests arriving during a hold are buffered and issued later.
module edge_signal_generator
    import edge_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             ovf_clr_i,
    output logic             signal_o,
    output logic             edge_done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_e             state_q,     state_d;
    logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic               signal_q,    signal_d;
    logic               edge_done_q, edge_done_d;
    logic               overflow_q,  overflow_d;

    logic               cnt_inc;
    logic               cnt_dec;
    logic               cnt_full;
    logic               cnt_drop;
    logic [CNT_W-1:0]   pending;

    sat_req_counter #(
        .CNT_W (CNT_W)
    ) u_pending (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .count_o (pending),
        .full_o  (cnt_full),
        .drop_o  (cnt_drop)
    );

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        signal_d    = signal_q;
        edge_done_d = 1'b0;
        cnt_inc     = 1'b0;
        cnt_dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    signal_d    = ~signal_q;
                    edge_done_d = 1'b1;
                    hold_cnt_d  = HOLD_LOAD;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q > HOLD_ONE) begin
                    hold_cnt_d = hold_cnt_q - HOLD_ONE;
                    cnt_inc    = tick_i;
                end else if (tick_i || (pending != '0)) begin
                    // Last hold cycle: a same-cycle tick is issued straight away
                    // (inc+dec cancel), otherwise one buffered request is consumed.
                    signal_d    = ~signal_q;
                    edge_done_d = 1'b1;
                    hold_cnt_d  = HOLD_LOAD;
                    cnt_inc     = tick_i;
                    cnt_dec     = 1'b1;
                end else begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cnt_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            signal_q    <= 1'b0;
            edge_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            signal_q    <= signal_d;
            edge_done_q <= edge_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign signal_o    = signal_q;
    assign edge_done_o = edge_done_q;
    assign busy_o      = (state_q == HOLD);
    assign pending_o   = pending;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_edge_signal_generator.sv
// tb/tb_edge_signal_generator.sv - directed vector table plus multi-cycle sequences
module tb_edge_signal_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       ovf_clr;
    logic       signal;
    logic       edge_done;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    always #5 clk = ~clk;

    edge_signal_generator #(
        .MIN_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .tick_i      (tick),
        .ovf_clr_i   (ovf_clr),
        .signal_o    (signal),
        .edge_done_o (edge_done),
        .busy_o      (busy),
        .pending_o   (pending),
        .overflow_o  (overflow)
    );

    typedef struct {
        logic       rst_n;
        logic       tick;
        logic       clr;
        logic       sig;
        logic       ed;
        logic       busy;
        logic [2:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    int   tog_cnt;
    int   last_tog;
    int   min_sp;
    int   max_sp;
    logic prev_sig;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic clear_stats();
        tog_cnt  = 0;
        last_tog = -1;
        min_sp   = 1000;
        max_sp   = 0;
        prev_sig = signal;
    endtask

    // Advance one clock, sample after the edge, and run a dual-edge detector on signal.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (signal !== prev_sig) begin
            tog_cnt++;
            if (last_tog >= 0) begin
                if (cycle - last_tog < min_sp) min_sp = cycle - last_tog;
                if (cycle - last_tog > max_sp) max_sp = cycle - last_tog;
            end
            last_tog = cycle;
        end
        prev_sig = signal;
    endtask

    function automatic void add(input logic r, input logic t, input logic c, input logic s,
                                input logic e, input logic b, input logic [2:0] p, input logic o);
        vec_t v;
        v.rst_n = r; v.tick = t; v.clr = c; v.sig = s;
        v.ed = e; v.busy = b; v.pend = p; v.ovf = o;
        vecs.push_back(v);
    endfunction

    initial begin
        int maxp;
        int n;

        // fields: rst_n tick clr | signal edge_done busy pending overflow
        add(0,1,0, 0,0,0,0,0);
        add(0,1,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(1,1,0, 1,1,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,0,0,0);
        add(1,0,1, 1,0,0,0,0);
        add(0,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        add(1,1,0, 1,1,1,0,0);
        add(1,1,0, 1,0,1,1,0);
        add(1,1,0, 1,0,1,2,0);
        add(1,0,0, 1,0,1,2,0);
        add(1,0,0, 0,1,1,1,0);
        add(1,0,0, 0,0,1,1,0);
        add(1,0,0, 0,0,1,1,0);
        add(1,0,0, 0,0,1,1,0);
        add(1,0,0, 1,1,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,0,0,0);
        add(1,0,0, 1,0,0,0,0);

        prev_sig = 1'b0;
        clear_stats();
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            tick    = vecs[i].tick;
            ovf_clr = vecs[i].clr;
            step();
            check($sformatf("vec%0d", i),
                  int'({signal, edge_done, busy, pending, overflow}),
                  int'({vecs[i].sig, vecs[i].ed, vecs[i].busy, vecs[i].pend, vecs[i].ovf}));
        end

        // Idle after reset: no toggles for 20 cycles.
        rst_n = 1'b0; tick = 1'b1; ovf_clr = 1'b0;
        step(); step();
        rst_n = 1'b1; tick = 1'b0;
        clear_stats();
        repeat (20) step();
        check("idle_toggles", tog_cnt, 0);
        check("idle_signal", int'(signal), 0);

        // Overflow: 12 back-to-back ticks, two dropped, set wins over clear.
        clear_stats();
        maxp = 0;
        for (int k = 1; k <= 12; k++) begin
            tick    = 1'b1;
            ovf_clr = (k == 12);
            step();
            if (int'(pending) > maxp) maxp = int'(pending);
            if (k == 10) check("ovf_before_drop", int'(overflow), 0);
            if (k == 11) check("ovf_on_drop", int'(overflow), 1);
            if (k == 12) check("ovf_set_wins", int'(overflow), 1);
        end
        tick = 1'b0; ovf_clr = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        check("ovf_drain_busy", int'(busy), 0);
        check("ovf_pending_max", maxp, 7);
        check("ovf_toggles", tog_cnt, 10);
        check("ovf_min_spacing", min_sp, 4);
        check("ovf_max_spacing", max_sp, 4);
        check("ovf_pending_end", int'(pending), 0);
        check("ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);

        // Reset mid-HOLD with requests still buffered.
        clear_stats();
        tick = 1'b1;
        repeat (5) step();
        tick = 1'b0;
        step(); step();
        check("mid_toggles", tog_cnt, 2);
        check("mid_pending", int'(pending), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_now", int'({signal, edge_done, busy, pending, overflow}), 0);
        step(); step();
        rst_n = 1'b1;
        clear_stats();
        repeat (20) step();
        check("mid_no_toggles", tog_cnt, 0);
        check("mid_idle", int'({signal, busy, pending}), 0);

        // Loopback: 50 ticks at random spacing of at least 4 cycles.
        clear_stats();
        for (int k = 0; k < 50; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            repeat ($urandom_range(3, 9)) step();
        end
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("loop_drain_busy", int'(busy), 0);
        check("loop_det_count", tog_cnt, 50);
        check("loop_spacing_ok", int'(min_sp >= 4), 1);
        check("loop_no_ovf", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
